// File: rtl/input_loader_pkg.sv
// Shared constants and types for the serial input loader.
//   IMG_BITS / WGT_BITS : default buffer sizes (28x28 pixels, 8 kernels x 3x3 weights)
//   PIX_CNT_W / WGT_CNT_W : counter widths, wide enough to hold the full count
//   state_e : loader FSM states
package input_loader_pkg;

  localparam int unsigned IMG_BITS  = 784;
  localparam int unsigned WGT_BITS  = 72;
  localparam int unsigned PIX_CNT_W = 10;
  localparam int unsigned WGT_CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

endpackage

// File: rtl/input_loader_edge_det.sv
// Rising-edge detector for the synchronized load strobe.
//   clk, reset_n : clock, asynchronous active-low reset
//   sig          : level input (already synchronized)
//   rise         : high for the one cycle where sig is high and was low last cycle
module edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic sig,
  output logic rise
);

  logic en_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q <= 1'b0;
    end else begin
      en_q <= sig;
    end
  end

  assign rise = sig & ~en_q;

endmodule

// File: rtl/input_loader.sv
// Serial loader that assembles a binarized image and weight set from a
// strobed bit-pair stream, then hands both buffers to the compute FSM.
//   clk, reset_n : clock, asynchronous active-low reset
//   sync_p/sync_w: synchronized pixel / weight serial bits
//   sync_en      : synchronized strobe; each rising edge carries one bit pair
//   ack          : compute FSM releases the buffers (honoured only in DONE)
//   image        : pixel buffer, pixel k at image[k]
//   weights      : weight buffer, weight k at weights[k]
//   pix_cnt      : pixels captured so far
//   load_done    : both buffers full and not yet acknowledged
//   overrun      : sticky, a strobe edge arrived while in DONE
module input_loader #(
  parameter int unsigned IMG_BITS = input_loader_pkg::IMG_BITS,
  parameter int unsigned WGT_BITS = input_loader_pkg::WGT_BITS
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   sync_p,
  input  logic                                   sync_w,
  input  logic                                   sync_en,
  input  logic                                   ack,
  output logic [IMG_BITS-1:0]                    image,
  output logic [WGT_BITS-1:0]                    weights,
  output logic [input_loader_pkg::PIX_CNT_W-1:0] pix_cnt,
  output logic                                   load_done,
  output logic                                   overrun
);

  import input_loader_pkg::*;

  localparam logic [PIX_CNT_W-1:0] PIX_MAX = PIX_CNT_W'(IMG_BITS);
  localparam logic [WGT_CNT_W-1:0] WGT_MAX = WGT_CNT_W'(WGT_BITS);

  state_e               state;
  logic [WGT_CNT_W-1:0] wgt_cnt;
  logic                 rise;

  logic                 pix_room;
  logic                 wgt_room;
  logic [PIX_CNT_W-1:0] pix_cnt_inc;
  logic [WGT_CNT_W-1:0] wgt_cnt_inc;
  logic                 load_full;

  edge_det u_edge_det (
    .clk     (clk),
    .reset_n (reset_n),
    .sig     (sync_en),
    .rise    (rise)
  );

  // Saturating counter increments; load_full looks at the post-capture counts
  // so DONE is entered straight off the final capture edge.
  always_comb begin
    pix_room    = (pix_cnt < PIX_MAX);
    wgt_room    = (wgt_cnt < WGT_MAX);
    pix_cnt_inc = pix_cnt + PIX_CNT_W'(pix_room);
    wgt_cnt_inc = wgt_cnt + WGT_CNT_W'(wgt_room);
    load_full   = (pix_cnt_inc == PIX_MAX) && (wgt_cnt_inc == WGT_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pix_cnt   <= '0;
      wgt_cnt   <= '0;
      image     <= '0;
      weights   <= '0;
      load_done <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, LOAD: begin
          // ack outside DONE is deliberately ignored
          if (rise) begin
            if (pix_room) image[pix_cnt]   <= sync_p;
            if (wgt_room) weights[wgt_cnt] <= sync_w;
            pix_cnt <= pix_cnt_inc;
            wgt_cnt <= wgt_cnt_inc;
            if (load_full) begin
              state     <= DONE;
              load_done <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        DONE: begin
          // Buffers are frozen here; a stray edge only flags overrun.
          if (rise) overrun <= 1'b1;
          if (ack) begin
            pix_cnt   <= '0;
            wgt_cnt   <= '0;
            state     <= IDLE;
            load_done <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          load_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_loader.sv
module tb_input_loader;
  import input_loader_pkg::*;

  logic         clk;
  logic         reset_n;
  logic         sync_p;
  logic         sync_w;
  logic         sync_en;
  logic         ack;
  logic [783:0] image;
  logic [71:0]  weights;
  logic [9:0]   pix_cnt;
  logic         load_done;
  logic         overrun;

  int n_tests;
  int n_fail;

  logic [783:0] exp_img;
  logic [71:0]  exp_wgt;
  logic [783:0] snap_img;
  logic [71:0]  snap_wgt;

  input_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sync_p    (sync_p),
    .sync_w    (sync_w),
    .sync_en   (sync_en),
    .ack       (ack),
    .image     (image),
    .weights   (weights),
    .pix_cnt   (pix_cnt),
    .load_done (load_done),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [799:0] got, input logic [799:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One strobe: strobe high for one rising edge, then low.
  task automatic strobe(input logic p, input logic w);
    @(negedge clk);
    sync_p  = p;
    sync_w  = w;
    sync_en = 1'b1;
    @(negedge clk);
    sync_en = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    sync_p  = 1'b0;
    sync_w  = 1'b0;
    sync_en = 1'b0;
    ack     = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_image", image, '0);
    check("rst_weights", weights, '0);
    check("rst_pix_cnt", pix_cnt, 0);
    check("rst_load_done", load_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", dut.state, IDLE);
    reset_n = 1'b1;

    // Held strobe: 10 cycles high gives exactly one capture
    @(negedge clk);
    sync_p  = 1'b1;
    sync_w  = 1'b1;
    sync_en = 1'b1;
    repeat (10) @(negedge clk);
    sync_en = 1'b0;
    check("held_pix_cnt", pix_cnt, 1);
    check("held_image", image, 1);
    check("held_weights", weights, 1);
    check("held_state", dut.state, LOAD);

    // Weight saturation after 100 strobes
    do_reset();
    check("rst2_pix_cnt", pix_cnt, 0);
    exp_img = '0;
    for (int k = 0; k < 784; k++) exp_img[k] = k[0];
    for (int k = 0; k < 100; k++) strobe(k[0], (k < 72) ? 1'b1 : 1'b0);
    check("sat_pix_cnt", pix_cnt, 100);
    check("sat_wgt_cnt", dut.wgt_cnt, 72);
    check("sat_weights", weights, {72{1'b1}});
    check("sat_load_done", load_done, 0);

    // ack during LOAD is ignored
    pulse_ack();
    check("ack_load_pix_cnt", pix_cnt, 100);
    check("ack_load_state", dut.state, LOAD);

    // Complete the load
    for (int k = 100; k < 783; k++) strobe(k[0], 1'b0);
    check("pre_final_load_done", load_done, 0);
    check("pre_final_pix_cnt", pix_cnt, 783);
    strobe(1'b1, 1'b0);
    check("full_load_done", load_done, 1);
    check("full_state", dut.state, DONE);
    check("full_image", image, exp_img);
    check("full_image_bit1", image[1], 1);
    check("full_weights", weights, {72{1'b1}});
    check("full_pix_cnt", pix_cnt, 784);

    // Overrun: extra strobe in DONE changes nothing but the flag
    strobe(1'b0, 1'b0);
    check("ovr_image", image, exp_img);
    check("ovr_weights", weights, {72{1'b1}});
    check("ovr_pix_cnt", pix_cnt, 784);
    check("ovr_flag", overrun, 1);
    check("ovr_load_done", load_done, 1);
    pulse_ack();
    check("ack_state", dut.state, IDLE);
    check("ack_pix_cnt", pix_cnt, 0);
    check("ack_wgt_cnt", dut.wgt_cnt, 0);
    check("ack_load_done", load_done, 0);
    check("ack_overrun", overrun, 1);
    check("ack_image_held", image, exp_img);

    // Reset mid-load clears everything at once, without a clock edge
    for (int k = 0; k < 300; k++) strobe(1'b1, 1'b1);
    check("mid_pix_cnt", pix_cnt, 300);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_image", image, '0);
    check("async_weights", weights, '0);
    check("async_pix_cnt", pix_cnt, 0);
    check("async_load_done", load_done, 0);
    check("async_overrun", overrun, 0);
    check("async_state", dut.state, IDLE);
    @(negedge clk);
    reset_n = 1'b1;

    // Clean reload with a different pattern
    exp_img = '0;
    exp_wgt = '0;
    for (int k = 0; k < 784; k++) exp_img[k] = (k % 5 == 0);
    for (int k = 0; k < 72; k++) exp_wgt[k] = (k % 3 == 0);
    for (int k = 0; k < 784; k++) strobe((k % 5 == 0), (k % 3 == 0));
    check("reload_image", image, exp_img);
    check("reload_weights", weights, exp_wgt);
    check("reload_load_done", load_done, 1);
    check("reload_overrun", overrun, 0);

    // Simultaneous ack and edge in DONE acts as ack, with overrun set
    @(negedge clk);
    ack     = 1'b1;
    sync_p  = 1'b0;
    sync_w  = 1'b1;
    sync_en = 1'b1;
    @(negedge clk);
    ack     = 1'b0;
    sync_en = 1'b0;
    check("sim_state", dut.state, IDLE);
    check("sim_pix_cnt", pix_cnt, 0);
    check("sim_image", image, exp_img);
    check("sim_weights", weights, exp_wgt);
    check("sim_overrun", overrun, 1);
    check("sim_load_done", load_done, 0);

    // Next strobe lands at bit 0 over the retained buffers
    snap_img    = exp_img;
    snap_img[0] = 1'b0;
    snap_wgt    = exp_wgt;
    snap_wgt[0] = 1'b0;
    strobe(1'b0, 1'b0);
    check("next_image", image, snap_img);
    check("next_weights", weights, snap_wgt);
    check("next_pix_cnt", pix_cnt, 1);
    check("next_state", dut.state, LOAD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_loader.md
INPUT_LOADER -- requirements
Module: input_loader

Interface
REQ-001 Parameter IMG_BITS, default 784, number of binarized pixel bits per image (28x28).
REQ-002 Parameter WGT_BITS, default 72, number of binarized weight bits per load (8 kernels x 3x3).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 sync_p  input  1  synchronized serial pixel bit from the 3-stage input synchronizer.
REQ-006 sync_w  input  1  synchronized serial weight bit from the synchronizer.
REQ-007 sync_en  input  1  synchronized load strobe; each rising edge marks one valid bit pair.
REQ-008 ack  input  1  single-cycle pulse from the compute FSM; releases the buffers for the next load.
REQ-009 image  output  IMG_BITS  pixel buffer; pixel k at image[k].
REQ-010 weights  output  WGT_BITS  weight buffer; weight k at weights[k].
REQ-011 pix_cnt  output  10  pixels captured so far, 0..IMG_BITS.
REQ-012 load_done  output  1  high while both buffers are complete and unacknowledged.
REQ-013 overrun  output  1  sticky flag: a strobe edge arrived while in DONE.

Function
REQ-014 The block SHALL register sync_en into en_q and define edge = sync_en & ~en_q; a level held high yields exactly one edge.
REQ-015 The FSM SHALL have states IDLE, LOAD and DONE, and SHALL reset to IDLE.
REQ-016 On an edge in IDLE, the block SHALL capture bit 0 of both streams and go to LOAD in the same cycle.
REQ-017 On an edge in IDLE or LOAD, with pix_cnt < IMG_BITS, it SHALL write image[pix_cnt] <= sync_p and increment pix_cnt.
REQ-018 On the same edge, with wgt_cnt < WGT_BITS, it SHALL write weights[wgt_cnt] <= sync_w and increment the internal counter wgt_cnt.
REQ-019 Once wgt_cnt = WGT_BITS, further sync_w bits SHALL be ignored while pixel capture continues.
REQ-020 Counters SHALL saturate at their limits and never wrap.
REQ-021 The FSM SHALL go to DONE on the cycle after the capture that makes pix_cnt = IMG_BITS and wgt_cnt = WGT_BITS.
REQ-022 load_done SHALL be registered and high exactly while in DONE, 1 cycle after the final capture edge.
REQ-023 An edge in DONE SHALL NOT modify image, weights or the counters, and SHALL set overrun.
REQ-024 ack in DONE SHALL clear pix_cnt and wgt_cnt, return to IDLE and drop load_done next cycle; image and weights SHALL hold their contents.
REQ-025 ack and an edge in the same DONE cycle SHALL behave as ack only, with overrun set.
REQ-026 ack in IDLE or LOAD SHALL be ignored.
REQ-027 overrun SHALL clear only on reset.

Reset
REQ-028 On reset_n low, immediately and regardless of clk: state IDLE, en_q 0, pix_cnt 0, wgt_cnt 0, image all 0, weights all 0, load_done 0, overrun 0.
REQ-029 Reset mid-LOAD SHALL discard the partial load; the next edge after release SHALL be captured as bit 0.

Structure
REQ-030 A shared package SHALL hold IMG_BITS, WGT_BITS, the counter widths and the state enum (IDLE, LOAD, DONE).
REQ-031 Edge detection SHALL be a sub-module named edge_det, used once; the rest stays in input_loader.

Verification
REQ-032 Full load: 784 strobes, p = k%2 and w = 1 for k < 72 -> image = alternating 0/1 with image[1] = 1, weights all 1, load_done high 1 cycle after strobe 784.
REQ-033 Held strobe: sync_en high for 10 cycles -> pix_cnt increments by exactly 1.
REQ-034 Overrun: after DONE, one extra strobe -> image and weights unchanged, overrun = 1; then ack -> IDLE, pix_cnt = 0, overrun stays 1.
REQ-035 Simultaneous ack and edge in DONE -> state IDLE, pix_cnt 0, no capture, overrun 1.
REQ-036 Reset after 300 strobes -> all outputs 0 immediately; next 784 strobes complete a clean load.
REQ-037 Weight saturation: 100 strobes with w = 1 -> weights all 1, wgt_cnt = 72, pix_cnt = 100, load_done 0.
